// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard and its MD busy counter.
package hazard_scoreboard_pkg;

    // Internal Tnew field width; the top zero-extends its TNEW_W inputs into it (TNEW_W up to 4).
    localparam int SB_TNEW_W = 4;

    // Bit positions inside stall_cause = {eret, md, data}.
    localparam int CAUSE_DATA = 0;
    localparam int CAUSE_MD   = 1;
    localparam int CAUSE_ERET = 2;

    // CP0 register number of EPC; an mtc0 to it is what eret must wait on.
    localparam logic [4:0] CP0_EPC_IDX = 5'd14;

    // One in-flight instruction after D: destination, cycles until forwardable, EPC write flag.
    typedef struct packed {
        logic                 valid;
        logic [4:0]           a3;
        logic [SB_TNEW_W-1:0] tnew;
        logic                 epc;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multiply/divide unit busy tracker: loads the op latency on a start, then counts down to idle.
module md_busy_counter #(
    parameter int CNT_W    = 4,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] count;

    // Load the latency of the starting op, otherwise decrement until zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard for a 5-stage MIPS pipeline: tracks E/M/W results,
// the MD unit and pending EPC writes, and raises stall for the instruction in D.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [4:0]        rs_D,
    input  logic [4:0]        rt_D,
    input  logic              use_rs_D,
    input  logic              use_rt_D,
    input  logic [TNEW_W-1:0] tuse_rs_D,
    input  logic [TNEW_W-1:0] tuse_rt_D,
    input  logic [4:0]        a3_D,
    input  logic [TNEW_W-1:0] tnew_D,
    input  logic              md_start_D,
    input  logic              md_div_D,
    input  logic              md_read_D,
    input  logic              mtc0_epc_D,
    input  logic              eret_D,
    input  logic              flush,
    output logic              stall,
    output logic [2:0]        stall_cause,
    output logic              md_busy
);

    sb_entry_t            sb [NSTAGE];
    sb_entry_t            d_entry;
    logic                 rs_found;
    logic                 rt_found;
    logic [SB_TNEW_W-1:0] rs_tnew;
    logic [SB_TNEW_W-1:0] rt_tnew;
    logic                 epc_pending;
    logic                 data_hz;
    logic                 md_hz;
    logic                 eret_hz;
    logic                 md_start;

    // Youngest-match lookup for each source, pending EPC writes, and the resulting stall.
    always_comb begin
        rs_found    = 1'b0;
        rt_found    = 1'b0;
        rs_tnew     = '0;
        rt_tnew     = '0;
        epc_pending = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (!rs_found && sb[i].valid && sb[i].a3 == rs_D) begin
                rs_found = 1'b1;
                rs_tnew  = sb[i].tnew;
            end
            if (!rt_found && sb[i].valid && sb[i].a3 == rt_D) begin
                rt_found = 1'b1;
                rt_tnew  = sb[i].tnew;
            end
            if (sb[i].valid && sb[i].epc) begin
                epc_pending = 1'b1;
            end
        end
        data_hz = d_valid &&
                  ((use_rs_D && rs_D != 5'd0 && rs_found && rs_tnew > SB_TNEW_W'(tuse_rs_D)) ||
                   (use_rt_D && rt_D != 5'd0 && rt_found && rt_tnew > SB_TNEW_W'(tuse_rt_D)));
        md_hz   = md_read_D && d_valid && md_busy;
        eret_hz = eret_D && d_valid && epc_pending;
        stall       = 1'b0;
        stall_cause = '0;
        if (!flush) begin
            stall                   = data_hz | md_hz | eret_hz;
            stall_cause[CAUSE_DATA] = data_hz;
            stall_cause[CAUSE_MD]   = md_hz;
            stall_cause[CAUSE_ERET] = eret_hz;
        end
    end

    // Entry for the instruction leaving D; an mtc0 to EPC occupies a slot even without a GPR destination.
    always_comb begin
        d_entry       = '0;
        d_entry.valid = d_valid & ((a3_D != 5'd0) | mtc0_epc_D);
        d_entry.a3    = a3_D;
        d_entry.tnew  = SB_TNEW_W'(tnew_D);
        d_entry.epc   = mtc0_epc_D;
    end

    // Advance every entry one stage toward W, aging tnew; flush empties the pipe, stall inserts a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSTAGE; i++) begin
                sb[i] <= '0;
            end
        end else begin
            if (flush || stall) begin
                sb[0] <= '0;
            end else begin
                sb[0] <= d_entry;
            end
            for (int i = 1; i < NSTAGE; i++) begin
                sb[i].valid <= sb[i-1].valid & ~flush;
                sb[i].a3    <= sb[i-1].a3;
                sb[i].tnew  <= (sb[i-1].tnew != '0) ? sb[i-1].tnew - SB_TNEW_W'(1) : '0;
                sb[i].epc   <= sb[i-1].epc;
            end
        end
    end

    // A flushed D instruction never issues, so it cannot start the MD unit; a running op is unaffected.
    assign md_start = md_start_D & d_valid & ~stall & ~flush;

    md_busy_counter #(
        .CNT_W    (CNT_W),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .is_div (md_div_D),
        .busy   (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: an issue-history model checked every cycle,
// plus hand-computed expectations for the classic hazard sequences.
module tb_hazard_scoreboard;

    localparam int NSTAGE   = 3;
    localparam int TNEW_W   = 2;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;

    typedef struct {
        bit         dv;
        logic [4:0] rs;
        logic [4:0] rt;
        bit         urs;
        bit         urt;
        logic [1:0] trs;
        logic [1:0] trt;
        logic [4:0] a3;
        logic [1:0] tnew;
        bit         mds;
        bit         mdd;
        bit         mdr;
        bit         epc;
        bit         eret;
    } instr_t;

    typedef struct {
        int a3;
        int tnew;
        bit epc;
        int issue;
    } rec_t;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [4:0]  rs_D;
    logic [4:0]  rt_D;
    logic        use_rs_D;
    logic        use_rt_D;
    logic [1:0]  tuse_rs_D;
    logic [1:0]  tuse_rt_D;
    logic [4:0]  a3_D;
    logic [1:0]  tnew_D;
    logic        md_start_D;
    logic        md_div_D;
    logic        md_read_D;
    logic        mtc0_epc_D;
    logic        eret_D;
    logic        flush;
    logic        stall;
    logic [2:0]  stall_cause;
    logic        md_busy;

    int          total;
    int          bad;
    int          cyc;
    int          md_end;
    bit          exp_stall;
    rec_t        hist[$];

    int          lit_seq;
    string       lit_name;
    bit          lit_stall;
    logic [2:0]  lit_cause;
    bit          lit_busy;

    hazard_scoreboard #(
        .NSTAGE   (NSTAGE),
        .TNEW_W   (TNEW_W),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .d_valid     (d_valid),
        .rs_D        (rs_D),
        .rt_D        (rt_D),
        .use_rs_D    (use_rs_D),
        .use_rt_D    (use_rt_D),
        .tuse_rs_D   (tuse_rs_D),
        .tuse_rt_D   (tuse_rt_D),
        .a3_D        (a3_D),
        .tnew_D      (tnew_D),
        .md_start_D  (md_start_D),
        .md_div_D    (md_div_D),
        .md_read_D   (md_read_D),
        .mtc0_epc_D  (mtc0_epc_D),
        .eret_D      (eret_D),
        .flush       (flush),
        .stall       (stall),
        .stall_cause (stall_cause),
        .md_busy     (md_busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic instr_t nop();
        instr_t x;
        x = '{default: '0};
        return x;
    endfunction

    function automatic instr_t wr(input logic [4:0] a3, input logic [1:0] tn);
        instr_t x;
        x      = nop();
        x.dv   = 1'b1;
        x.a3   = a3;
        x.tnew = tn;
        return x;
    endfunction

    function automatic instr_t rd_rs(input logic [4:0] r, input logic [1:0] tu);
        instr_t x;
        x     = nop();
        x.dv  = 1'b1;
        x.rs  = r;
        x.urs = 1'b1;
        x.trs = tu;
        return x;
    endfunction

    function automatic instr_t rd_rt(input logic [4:0] r, input logic [1:0] tu);
        instr_t x;
        x     = nop();
        x.dv  = 1'b1;
        x.rt  = r;
        x.urt = 1'b1;
        x.trt = tu;
        return x;
    endfunction

    function automatic instr_t md_op(input bit is_div);
        instr_t x;
        x     = nop();
        x.dv  = 1'b1;
        x.mds = 1'b1;
        x.mdd = is_div;
        x.mdr = 1'b1;
        return x;
    endfunction

    function automatic instr_t mflo();
        instr_t x;
        x      = wr(5'd2, 2'd1);
        x.mdr  = 1'b1;
        return x;
    endfunction

    function automatic instr_t mtc0_epc();
        instr_t x;
        x     = nop();
        x.dv  = 1'b1;
        x.epc = 1'b1;
        return x;
    endfunction

    function automatic instr_t eret_i();
        instr_t x;
        x      = nop();
        x.dv   = 1'b1;
        x.eret = 1'b1;
        return x;
    endfunction

    // Model: hazard on source r from the most recently issued writer of r still in E..W.
    function automatic bit src_hz(input bit used, input logic [4:0] r, input logic [1:0] tuse);
        int age;
        int rem;
        if (!used || r == 5'd0) return 1'b0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            age = cyc - hist[i].issue;
            if (age < NSTAGE && hist[i].a3 == int'(r)) begin
                rem = hist[i].tnew - age;
                if (rem < 0) rem = 0;
                return rem > int'(tuse);
            end
        end
        return 1'b0;
    endfunction

    function automatic bit epc_live();
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].epc && (cyc - hist[i].issue) < NSTAGE) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive(input instr_t x, input bit fl);
        d_valid    = x.dv;
        rs_D       = x.rs;
        rt_D       = x.rt;
        use_rs_D   = x.urs;
        use_rt_D   = x.urt;
        tuse_rs_D  = x.trs;
        tuse_rt_D  = x.trt;
        a3_D       = x.a3;
        tnew_D     = x.tnew;
        md_start_D = x.mds;
        md_div_D   = x.mdd;
        md_read_D  = x.mdr;
        mtc0_epc_D = x.epc;
        eret_D     = x.eret;
        flush      = fl;
    endtask

    task automatic applyStimulus(input instr_t x, input bit fl);
        @(posedge clk);
        #1;
        drive(x, fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(nop(), 1'b0);
    endtask

    // Posts a hand-computed expectation for the current cycle; the compare process checks it.
    task automatic checkOutput(input string name, input bit s, input logic [2:0] c, input bit b);
        lit_name  = name;
        lit_stall = s;
        lit_cause = c;
        lit_busy  = b;
        lit_seq   = lit_seq + 1;
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        int   last_lit;
        bit   e_data;
        bit   e_md;
        bit   e_eret;
        bit   e_busy;
        logic [2:0] e_cause;
        rec_t r;
        total     = 0;
        bad       = 0;
        cyc       = 0;
        md_end    = 0;
        exp_stall = 1'b0;
        last_lit  = 0;
        forever begin
            @(negedge clk);
            if (lit_seq != last_lit) begin
                last_lit = lit_seq;
                total++;
                if (stall !== lit_stall || stall_cause !== lit_cause || md_busy !== lit_busy) begin
                    bad++;
                    $display("[TB] FAIL %s: got stall=%b cause=%b busy=%b, want stall=%b cause=%b busy=%b",
                             lit_name, stall, stall_cause, md_busy, lit_stall, lit_cause, lit_busy);
                end
            end
            if (reset) begin
                e_busy  = cyc < md_end;
                e_data  = d_valid && (src_hz(use_rs_D, rs_D, tuse_rs_D) || src_hz(use_rt_D, rt_D, tuse_rt_D));
                e_md    = d_valid && md_read_D && e_busy;
                e_eret  = d_valid && eret_D && epc_live();
                e_cause = flush ? 3'b000 : {e_eret, e_md, e_data};
                exp_stall = (e_cause != 3'b000);
                total++;
                if (stall !== exp_stall || stall_cause !== e_cause || md_busy !== e_busy) begin
                    bad++;
                    $display("[TB] FAIL model cycle %0d: got stall=%b cause=%b busy=%b, want stall=%b cause=%b busy=%b",
                             cyc, stall, stall_cause, md_busy, exp_stall, e_cause, e_busy);
                end
            end else begin
                exp_stall = 1'b0;
            end
            @(posedge clk);
            cyc++;
            if (!reset) begin
                hist.delete();
                md_end = 0;
            end else begin
                if (flush) begin
                    hist.delete();
                end else if (!exp_stall && d_valid && (a3_D != 5'd0 || mtc0_epc_D)) begin
                    r.a3    = int'(a3_D);
                    r.tnew  = int'(tnew_D);
                    r.epc   = mtc0_epc_D;
                    r.issue = cyc;
                    hist.push_back(r);
                end
                if (!flush && !exp_stall && d_valid && md_start_D) begin
                    md_end = cyc + (md_div_D ? DIV_LAT : MULT_LAT);
                end
                while (hist.size() > 0 && cyc - hist[0].issue >= NSTAGE) begin
                    void'(hist.pop_front());
                end
            end
        end
    end

    // Directed sequences with hand-derived stall/cause/busy expectations.
    initial begin
        lit_seq = 0;
        reset   = 1'b0;
        drive(nop(), 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_state", 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(wr(5'd8, 2'd2), 1'b0);
        checkOutput("lw_first_after_reset", 1'b0, 3'b000, 1'b0);
        applyStimulus(rd_rs(5'd8, 2'd1), 1'b0);
        checkOutput("lw_use_stall", 1'b1, 3'b001, 1'b0);
        applyStimulus(rd_rs(5'd8, 2'd1), 1'b0);
        checkOutput("lw_use_release", 1'b0, 3'b000, 1'b0);
        idle(3);

        applyStimulus(wr(5'd9, 2'd1), 1'b0);
        applyStimulus(rd_rs(5'd9, 2'd0), 1'b0);
        checkOutput("alu_beq_stall", 1'b1, 3'b001, 1'b0);
        applyStimulus(rd_rs(5'd9, 2'd0), 1'b0);
        checkOutput("alu_beq_release", 1'b0, 3'b000, 1'b0);
        applyStimulus(wr(5'd0, 2'd1), 1'b0);
        applyStimulus(rd_rs(5'd0, 2'd0), 1'b0);
        checkOutput("reg0_no_stall", 1'b0, 3'b000, 1'b0);
        idle(3);

        applyStimulus(wr(5'd7, 2'd2), 1'b0);
        applyStimulus(rd_rt(5'd7, 2'd1), 1'b0);
        checkOutput("rt_stall", 1'b1, 3'b001, 1'b0);
        applyStimulus(rd_rt(5'd7, 2'd1), 1'b0);
        checkOutput("rt_release", 1'b0, 3'b000, 1'b0);
        idle(3);

        applyStimulus(wr(5'd5, 2'd1), 1'b0);
        applyStimulus(wr(5'd5, 2'd2), 1'b0);
        applyStimulus(rd_rs(5'd5, 2'd0), 1'b0);
        checkOutput("youngest_stall1", 1'b1, 3'b001, 1'b0);
        applyStimulus(rd_rs(5'd5, 2'd0), 1'b0);
        checkOutput("youngest_stall2", 1'b1, 3'b001, 1'b0);
        applyStimulus(rd_rs(5'd5, 2'd0), 1'b0);
        checkOutput("youngest_release", 1'b0, 3'b000, 1'b0);
        idle(3);

        applyStimulus(wr(5'd6, 2'd2), 1'b0);
        applyStimulus(wr(5'd6, 2'd0), 1'b0);
        applyStimulus(rd_rs(5'd6, 2'd0), 1'b0);
        checkOutput("older_match_ignored", 1'b0, 3'b000, 1'b0);
        idle(3);

        applyStimulus(md_op(1'b1), 1'b0);
        checkOutput("div_issue", 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < DIV_LAT; i++) begin
            applyStimulus(mflo(), 1'b0);
            checkOutput("div_mflo_stall", 1'b1, 3'b010, 1'b1);
        end
        applyStimulus(mflo(), 1'b0);
        checkOutput("div_mflo_release", 1'b0, 3'b000, 1'b0);
        idle(3);

        applyStimulus(md_op(1'b0), 1'b0);
        for (int i = 0; i < MULT_LAT; i++) begin
            applyStimulus(mflo(), 1'b0);
            checkOutput("mult_mflo_stall", 1'b1, 3'b010, 1'b1);
        end
        applyStimulus(mflo(), 1'b0);
        checkOutput("mult_mflo_release", 1'b0, 3'b000, 1'b0);
        idle(3);

        applyStimulus(md_op(1'b1), 1'b0);
        applyStimulus(wr(5'd10, 2'd2), 1'b0);
        begin
            instr_t mthi;
            mthi     = rd_rs(5'd10, 2'd1);
            mthi.mdr = 1'b1;
            applyStimulus(mthi, 1'b0);
            checkOutput("data_and_md", 1'b1, 3'b011, 1'b1);
            applyStimulus(mthi, 1'b0);
            checkOutput("md_only", 1'b1, 3'b010, 1'b1);
            for (int i = 0; i < DIV_LAT; i++) applyStimulus(mthi, 1'b0);
        end
        idle(3);

        applyStimulus(mtc0_epc(), 1'b0);
        for (int i = 0; i < NSTAGE; i++) begin
            applyStimulus(eret_i(), 1'b0);
            checkOutput("eret_stall", 1'b1, 3'b100, 1'b0);
        end
        applyStimulus(eret_i(), 1'b0);
        checkOutput("eret_release", 1'b0, 3'b000, 1'b0);
        idle(3);

        applyStimulus(mtc0_epc(), 1'b0);
        applyStimulus(eret_i(), 1'b0);
        checkOutput("eret_before_flush", 1'b1, 3'b100, 1'b0);
        applyStimulus(eret_i(), 1'b1);
        checkOutput("flush_forces_no_stall", 1'b0, 3'b000, 1'b0);
        applyStimulus(eret_i(), 1'b0);
        checkOutput("eret_after_flush", 1'b0, 3'b000, 1'b0);
        idle(3);

        applyStimulus(wr(5'd11, 2'd2), 1'b0);
        applyStimulus(nop(), 1'b1);
        applyStimulus(rd_rs(5'd11, 2'd0), 1'b0);
        checkOutput("flush_clears_entries", 1'b0, 3'b000, 1'b0);
        idle(3);

        applyStimulus(md_op(1'b0), 1'b0);
        applyStimulus(nop(), 1'b1);
        applyStimulus(mflo(), 1'b0);
        checkOutput("flush_keeps_md", 1'b1, 3'b010, 1'b1);
        for (int i = 0; i < MULT_LAT; i++) applyStimulus(mflo(), 1'b0);
        idle(3);

        applyStimulus(md_op(1'b1), 1'b0);
        applyStimulus(mflo(), 1'b0);
        checkOutput("div_before_reset", 1'b1, 3'b010, 1'b1);
        applyStimulus(mflo(), 1'b0);
        reset = 1'b0;
        checkOutput("reset_aborts_md", 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(mflo(), 1'b0);
        checkOutput("mflo_after_release", 1'b0, 3'b000, 1'b0);
        applyStimulus(mflo(), 1'b0);
        checkOutput("mflo_after_release2", 1'b0, 3'b000, 1'b0);
        idle(3);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
